// File: rtl/ls191_sync_decoder_if.sv
// Control/data bus between the sync decoder and the two-stage LS191 horizontal counter cascade.
interface ls191_sync_decoder_if;
   logic [7:0] hpos;
   logic       cnt_en_n;
   logic       cnt_du;
   logic       load_n;
   logic [7:0] load_data;

   modport master (
      input  hpos,
      output cnt_en_n, cnt_du, load_n, load_data
   );

   modport slave (
      output hpos,
      input  cnt_en_n, cnt_du, load_n, load_data
   );
endinterface

// File: rtl/ls191_sync_decoder.sv
// Horizontal/vertical sync decoder driving the LS191 horizontal counter cascade;
// issues the end-of-line reload and runs the vertical line FSM.
module ls191_sync_decoder #(
   parameter logic [7:0]  H_RELOAD     = 8'd0,
   parameter logic [7:0]  H_LAST       = 8'd255,
   parameter logic [7:0]  H_ACT_END    = 8'd240,
   parameter logic [7:0]  H_SYNC_START = 8'd244,
   parameter logic [7:0]  H_SYNC_END   = 8'd252,
   parameter int unsigned V_ACTIVE     = 240,
   parameter int unsigned V_FP         = 4,
   parameter int unsigned V_SYNC       = 4,
   parameter int unsigned V_BP         = 14
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   ls191_sync_decoder_if.master cnt,
   output logic                 hsync_n,
   output logic                 hblank,
   output logic                 vsync_n,
   output logic                 vblank,
   output logic [8:0]           vpos,
   output logic                 line_start,
   output logic                 frame_start
);

   localparam int unsigned V_TOTAL     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam logic [8:0]  V_FP_LINE   = 9'(V_ACTIVE);
   localparam logic [8:0]  V_SYNC_LINE = 9'(V_ACTIVE + V_FP);
   localparam logic [8:0]  V_BP_LINE   = 9'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [8:0]  V_LAST      = 9'(V_TOTAL - 1);

   typedef enum logic [2:0] {INIT, ACTIVE, FPORCH, SYNC, BPORCH} state_t;

   state_t     state;
   state_t     state_nx;
   logic       armed;
   logic       line_end;
   logic [8:0] vpos_inc;

   assign cnt.cnt_du    = 1'b0;
   assign cnt.load_data = H_RELOAD;

   // armed blocks a second reload while hpos is stuck at H_LAST: one load per line
   assign line_end = en && (state != INIT) && armed && (cnt.hpos == H_LAST);

   always_comb begin
      vpos_inc = (vpos == V_LAST) ? '0 : vpos + 9'd1;
      state_nx = state;
      case (state)
         ACTIVE:  if (vpos_inc == V_FP_LINE)   state_nx = FPORCH;
         FPORCH:  if (vpos_inc == V_SYNC_LINE) state_nx = SYNC;
         SYNC:    if (vpos_inc == V_BP_LINE)   state_nx = BPORCH;
         BPORCH:  if (vpos_inc == '0)          state_nx = ACTIVE;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= INIT;
         armed        <= 1'b0;
         cnt.load_n   <= 1'b1;
         cnt.cnt_en_n <= 1'b1;
         hsync_n      <= 1'b1;
         hblank       <= 1'b0;
         vsync_n      <= 1'b1;
         vblank       <= 1'b0;
         vpos         <= '0;
         line_start   <= 1'b0;
         frame_start  <= 1'b0;
      end else begin
         cnt.load_n  <= 1'b1;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
         if (state == INIT) begin
            // counter contents are unknown until the first load
            hsync_n <= 1'b1;
            hblank  <= 1'b0;
            vsync_n <= 1'b1;
            vblank  <= 1'b0;
            if (en) begin
               cnt.load_n   <= 1'b0;
               cnt.cnt_en_n <= 1'b0;
               line_start   <= 1'b1;
               frame_start  <= 1'b1;
               vpos         <= '0;
               armed        <= 1'b0;
               state        <= ACTIVE;
            end
         end else begin
            cnt.cnt_en_n <= ~en;
            hblank       <= (cnt.hpos >= H_ACT_END);
            hsync_n      <= !((cnt.hpos >= H_SYNC_START) && (cnt.hpos < H_SYNC_END));
            if (cnt.hpos != H_LAST) armed <= 1'b1;
            if (line_end) begin
               cnt.load_n  <= 1'b0;
               line_start  <= 1'b1;
               frame_start <= (vpos_inc == '0);
               vpos        <= vpos_inc;
               armed       <= 1'b0;
               state       <= state_nx;
               vblank      <= (state_nx != ACTIVE);
               vsync_n     <= (state_nx != SYNC);
            end
         end
      end
   end

endmodule

// File: tb/tb_ls191_sync_decoder.sv
// Directed bench for ls191_sync_decoder with a behavioural LS191 pair model on the cascade bus.
module tb_ls191_sync_decoder;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       hsync_n, hblank, vsync_n, vblank, line_start, frame_start;
   logic [8:0] vpos;

   logic [7:0] q = 8'hA5;
   logic       ovr = 1'b1;
   logic [7:0] ovr_val = 8'hF6;
   logic       skip = 1'b0;

   int checks = 0;
   int failures = 0;
   int exp_v = 0;
   int fs_stray = 0;

   ls191_sync_decoder_if bus();

   always #5 clk = ~clk;

   assign bus.hpos = ovr ? ovr_val : q;

   // LS191 pair: async parallel load, count up when enabled; skip shortens lines
   always @(posedge clk or negedge bus.load_n) begin
      if (!bus.load_n) q <= bus.load_data;
      else if (!bus.cnt_en_n) q <= (skip && q == 8'd1) ? 8'd250 : q + 8'd1;
   end

   ls191_sync_decoder #(
      .H_RELOAD(8'd0), .H_LAST(8'd255), .H_ACT_END(8'd240),
      .H_SYNC_START(8'd244), .H_SYNC_END(8'd252),
      .V_ACTIVE(240), .V_FP(4), .V_SYNC(4), .V_BP(14)
   ) u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .cnt(bus),
      .hsync_n(hsync_n), .hblank(hblank), .vsync_n(vsync_n), .vblank(vblank),
      .vpos(vpos), .line_start(line_start), .frame_start(frame_start)
   );

   task automatic wait_line(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 400 && !ok; i++) begin
         @(negedge clk);
         if (line_start === 1'b1) ok = 1'b1;
         else if (frame_start !== 1'b0) fs_stray++;
      end
   endtask

   task automatic test_reset;
      rst_n = 1'b0; en = 1'b0; ovr = 1'b1; ovr_val = 8'hF6; skip = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.load_n, bus.cnt_en_n, hsync_n, vsync_n, hblank, vblank, line_start, frame_start} !== 8'b1111_0000) begin
         failures++;
         $display("FAIL reset_flags got=%b exp=%b", {bus.load_n, bus.cnt_en_n, hsync_n, vsync_n, hblank, vblank, line_start, frame_start}, 8'b1111_0000);
      end
      checks++;
      if (vpos !== 9'd0) begin failures++; $display("FAIL reset_vpos got=%0d exp=0", vpos); end
      checks++;
      if ({bus.cnt_du, bus.load_data} !== 9'd0) begin
         failures++; $display("FAIL const_outputs got=%h exp=000", {bus.cnt_du, bus.load_data});
      end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.load_n, bus.cnt_en_n, hsync_n, vsync_n, hblank, vblank, line_start, frame_start} !== 8'b1111_0000) begin
         failures++;
         $display("FAIL init_idle got=%b exp=%b", {bus.load_n, bus.cnt_en_n, hsync_n, vsync_n, hblank, vblank, line_start, frame_start}, 8'b1111_0000);
      end
      ovr = 1'b0; en = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.load_n, line_start, frame_start, bus.cnt_en_n} !== 4'b0110) begin
         failures++; $display("FAIL init_load got=%b exp=0110", {bus.load_n, line_start, frame_start, bus.cnt_en_n});
      end
      checks++;
      if ({hsync_n, hblank} !== 2'b10) begin failures++; $display("FAIL init_hdec got=%b exp=10", {hsync_n, hblank}); end
      checks++;
      if (vpos !== 9'd0) begin failures++; $display("FAIL init_vpos got=%0d exp=0", vpos); end
      checks++;
      if (bus.hpos !== 8'h00) begin failures++; $display("FAIL init_reload got=%h exp=00", bus.hpos); end
      @(negedge clk);
      checks++;
      if ({bus.load_n, line_start, frame_start} !== 3'b100) begin
         failures++; $display("FAIL init_pulse_width got=%b exp=100", {bus.load_n, line_start, frame_start});
      end
      exp_v = 0;
   endtask

   task automatic test_line_timing;
      bit found;
      int per;
      int hs_lo;
      int hb_hi;
      logic [7:0] ph;
      logic exp_hb, exp_hs;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (bus.load_n === 1'b0) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL line_first_load got=none exp=pulse"); return; end
      exp_v = 1;
      checks++;
      if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL line1_vpos got=%0d exp=%0d", vpos, exp_v); end
      ph = bus.hpos; per = 0; hs_lo = 0; hb_hi = 0; found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         per++;
         exp_hb = (ph >= 8'd240);
         exp_hs = !((ph >= 8'd244) && (ph < 8'd252));
         checks++;
         if (hblank !== exp_hb) begin failures++; $display("FAIL hblank_decode hpos=%0d got=%b exp=%b", ph, hblank, exp_hb); end
         checks++;
         if (hsync_n !== exp_hs) begin failures++; $display("FAIL hsync_decode hpos=%0d got=%b exp=%b", ph, hsync_n, exp_hs); end
         if (hsync_n === 1'b0) hs_lo++;
         if (hblank === 1'b1) hb_hi++;
         if (bus.load_n === 1'b0) found = 1'b1;
         ph = bus.hpos;
      end
      checks++;
      if (per !== 257) begin failures++; $display("FAIL line_period got=%0d exp=257", per); end
      checks++;
      if (hs_lo !== 8) begin failures++; $display("FAIL hsync_width got=%0d exp=8", hs_lo); end
      checks++;
      if (hb_hi !== 16) begin failures++; $display("FAIL hblank_width got=%0d exp=16", hb_hi); end
      exp_v = 2;
      checks++;
      if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL line2_vpos got=%0d exp=%0d", vpos, exp_v); end
   endtask

   task automatic test_en_drop;
      bit found;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (bus.hpos === 8'd99) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL en_drop_reach got=none exp=hpos99"); return; end
      en = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         checks++;
         if ({bus.cnt_en_n, bus.load_n, bus.hpos} !== {1'b1, 1'b1, 8'd100}) begin
            failures++; $display("FAIL en_drop_hold cyc=%0d got=%b_%b_%0d exp=1_1_100", i, bus.cnt_en_n, bus.load_n, bus.hpos);
         end
      end
      en = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.cnt_en_n, bus.hpos} !== {1'b0, 8'd100}) begin
         failures++; $display("FAIL en_resume_enable got=%b_%0d exp=0_100", bus.cnt_en_n, bus.hpos);
      end
      @(negedge clk);
      checks++;
      if (bus.hpos !== 8'd101) begin failures++; $display("FAIL en_resume_hpos got=%0d exp=101", bus.hpos); end
      checks++;
      if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL en_drop_vpos got=%0d exp=%0d", vpos, exp_v); end
   endtask

   task automatic test_back_to_back;
      bit found;
      int loads;
      int starts;
      found = 1'b0;
      for (int i = 0; i < 600 && !found; i++) begin
         @(negedge clk);
         if (bus.hpos === 8'd110) found = 1'b1;
      end
      checks++;
      if (!found) begin failures++; $display("FAIL stuck_reach got=none exp=hpos110"); return; end
      ovr_val = 8'd255; ovr = 1'b1;
      loads = 0; starts = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.load_n === 1'b0) loads++;
         if (line_start === 1'b1) starts++;
         if (i == 2) ovr = 1'b0;
      end
      exp_v = exp_v + 1;
      checks++;
      if (loads !== 1) begin failures++; $display("FAIL stuck_loads got=%0d exp=1", loads); end
      checks++;
      if (starts !== 1) begin failures++; $display("FAIL stuck_line_starts got=%0d exp=1", starts); end
      checks++;
      if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL stuck_vpos got=%0d exp=%0d", vpos, exp_v); end
   endtask

   task automatic test_frame;
      bit ok;
      logic exp_vb, exp_vs, exp_fs;
      @(negedge clk);
      rst_n = 1'b0; skip = 1'b1; en = 1'b1; ovr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.load_n, frame_start, line_start} !== 3'b011 || vpos !== 9'd0) begin
         failures++; $display("FAIL frame_init got=%b_%0d exp=011_0", {bus.load_n, frame_start, line_start}, vpos);
      end
      exp_v = 0; fs_stray = 0;
      for (int ln = 1; ln <= 262; ln++) begin
         wait_line(ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL frame_line_timeout line=%0d got=none exp=line_start", ln); return; end
         exp_v = (exp_v == 261) ? 0 : exp_v + 1;
         exp_vb = (exp_v >= 240);
         exp_vs = !((exp_v >= 244) && (exp_v <= 247));
         exp_fs = (exp_v == 0);
         checks++;
         if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL frame_vpos got=%0d exp=%0d", vpos, exp_v); end
         checks++;
         if (vblank !== exp_vb) begin failures++; $display("FAIL frame_vblank line=%0d got=%b exp=%b", exp_v, vblank, exp_vb); end
         checks++;
         if (vsync_n !== exp_vs) begin failures++; $display("FAIL frame_vsync line=%0d got=%b exp=%b", exp_v, vsync_n, exp_vs); end
         checks++;
         if (frame_start !== exp_fs) begin failures++; $display("FAIL frame_start line=%0d got=%b exp=%b", exp_v, frame_start, exp_fs); end
         checks++;
         if (bus.load_n !== 1'b0) begin failures++; $display("FAIL line_start_load line=%0d got=%b exp=0", exp_v, bus.load_n); end
      end
      checks++;
      if (fs_stray !== 0) begin failures++; $display("FAIL frame_start_stray got=%0d exp=0", fs_stray); end
   endtask

   task automatic test_reset_mid;
      bit ok;
      for (int ln = 1; ln <= 245; ln++) begin
         wait_line(ok);
         checks++;
         if (!ok) begin failures++; $display("FAIL midrst_line_timeout line=%0d got=none exp=line_start", ln); return; end
         exp_v = exp_v + 1;
         checks++;
         if (vpos !== 9'(exp_v)) begin failures++; $display("FAIL midrst_vpos got=%0d exp=%0d", vpos, exp_v); end
      end
      repeat (2) @(negedge clk);
      checks++;
      if ({vsync_n, vblank} !== 2'b01) begin failures++; $display("FAIL midrst_in_sync got=%b exp=01", {vsync_n, vblank}); end
      #2 rst_n = 1'b0;
      #1;
      checks++;
      if ({vsync_n, vblank, bus.load_n, bus.cnt_en_n, hsync_n, hblank, line_start, frame_start} !== 8'b1011_1000) begin
         failures++;
         $display("FAIL midrst_async got=%b exp=10111000", {vsync_n, vblank, bus.load_n, bus.cnt_en_n, hsync_n, hblank, line_start, frame_start});
      end
      checks++;
      if (vpos !== 9'd0) begin failures++; $display("FAIL midrst_vpos0 got=%0d exp=0", vpos); end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.load_n, frame_start, line_start} !== 3'b011 || vpos !== 9'd0) begin
         failures++; $display("FAIL midrst_reinit got=%b_%0d exp=011_0", {bus.load_n, frame_start, line_start}, vpos);
      end
      @(negedge clk);
      checks++;
      if (bus.load_n !== 1'b1) begin failures++; $display("FAIL midrst_load_width got=%b exp=1", bus.load_n); end
   endtask

   initial begin
      test_reset();
      test_line_timing();
      test_en_drop();
      test_back_to_back();
      test_frame();
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/ls191_sync_decoder.md
Name: ls191_sync_decoder

Overview:
- Sits directly downstream of the horizontal LS191 counter cascade: two LS191 nibble stages, low nibble then high nibble, 8-bit hpos.
- Decodes hpos into horizontal sync/blank, runs the vertical line FSM, and drives the cascade's control inputs back to it: load, count enable, direction, load data.
- Feeds the video/sprite pipeline with registered timing strobes.

Parameters:
- H_RELOAD, 8'd0, value loaded into the counter cascade at end of line.
- H_LAST, 8'd255, final hpos of a line; triggers the reload.
- H_ACT_END, 8'd240, first hpos of horizontal blanking.
- H_SYNC_START, 8'd244, first hpos with hsync asserted.
- H_SYNC_END, 8'd252, first hpos after hsync.
- V_ACTIVE, 240, active lines per frame.
- V_FP, 4, front-porch lines.
- V_SYNC, 4, vsync lines.
- V_BP, 14, back-porch lines. V_TOTAL = sum of the four = 262.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  timing run enable from upstream.
- hpos  in  8  {high-stage qd..qa, low-stage qd..qa} from the counter cascade.
- cnt_en_n  out  1  to CTEN of both stages; 0 = count.
- cnt_du  out  1  to DU of both stages; constant 0 (count up).
- load_n  out  1  to load of both stages; active-low, one clk wide.
- load_data  out  8  {d,c,b,a} of high/low stages; constant H_RELOAD.
- hsync_n  out  1  horizontal sync, active low.
- hblank  out  1  horizontal blank.
- vsync_n  out  1  vertical sync, active low.
- vblank  out  1  vertical blank.
- vpos  out  9  current line, 0..V_TOTAL-1.
- line_start  out  1  one-cycle strobe, coincident with load_n low.
- frame_start  out  1  one-cycle strobe, first line_start of line 0.

Behaviour:
- All outputs registered except cnt_du and load_data, which are constants.
- Reset values:
  - load_n=1, cnt_en_n=1, hsync_n=1, vsync_n=1.
  - hblank=0, vblank=0, vpos=0, line_start=0, frame_start=0.
  - FSM=INIT.
- FSM states: INIT, ACTIVE, FPORCH, SYNC, BPORCH.
- INIT:
  - The LS191 has no reset, so hpos is unknown; all h/v decodes are forced inactive.
  - On the first edge with en=1: load_n=0 for one cycle, line_start=1, frame_start=1, vpos=0, cnt_en_n=0, next state ACTIVE.
- line_end event: registered when en=1 and sampled hpos==H_LAST. Next cycle:
  - load_n=0 and line_start=1.
  - The counter loads H_RELOAD asynchronously.
- On line_end, vpos increments; V_TOTAL-1 wraps to 0 with frame_start=1 in the same cycle as line_start.
- State transitions on line_end, by the new vpos value:
  - ACTIVE to FPORCH at V_ACTIVE.
  - FPORCH to SYNC at V_ACTIVE+V_FP.
  - SYNC to BPORCH at V_ACTIVE+V_FP+V_SYNC.
  - BPORCH to ACTIVE at 0.
- Vertical outputs change in the same cycle as the vpos update:
  - vblank=1 in every state except ACTIVE and INIT.
  - vsync_n=0 only in SYNC.
- Horizontal decode, one-cycle latency from sampled hpos:
  - hblank=1 iff hpos>=H_ACT_END.
  - hsync_n=0 iff H_SYNC_START<=hpos<H_SYNC_END.
- en=0 (outside INIT):
  - cnt_en_n=1 next cycle, so the counter holds.
  - No line_end is generated; FSM, vpos, vsync_n and vblank hold.
  - The h decodes keep tracking hpos.
- en re-asserted: cnt_en_n=0 next cycle and counting resumes from the held hpos; no reload.
- hpos==H_LAST while load_n is already 0 (back-to-back): no second line_end; at most one load per line.
- Async reset mid-line or mid-frame: all outputs go to reset values immediately; the counter is re-initialised via INIT.
- Line period, with the LS191 async load and hold during the load cycle: H_LAST-H_RELOAD+2 clks (257 at defaults).

Test Plan:
- Reset, then en=1 with hpos=8'hA5 (X-model): load_n low exactly 1 cycle after the first edge, frame_start=1, vpos=0; hsync_n/hblank stay inactive throughout INIT.
- Free-run against a behavioural LS191 pair model with defaults:
  - load_n pulses every 257 clks.
  - hblank rises 1 clk after hpos=240.
  - hsync_n low for hpos 244..251 (8 clks, 1 clk latency).
- Run 262 lines:
  - vblank rises on line_start of line 240.
  - vsync_n low lines 244..247.
  - vpos wraps 261 to 0 with frame_start=1, and frame_start is high for 1 clk per frame only.
- Drop en at hpos=100 for 20 clks: cnt_en_n=1 for 20 clks, hpos holds at 100, no load_n pulse, vpos unchanged; resumes at 101.
- Force hpos=255 for 3 consecutive clks (stuck counter): exactly one load_n pulse and one vpos increment.
- Assert rst_n low in SYNC at vpos=245: vsync_n=1, vpos=0, state INIT immediately; the next en=1 edge issues an init load.
